// File: rtl/imem_loader.sv
// Splits 32-bit words from a valid/ready stream into four little-endian byte writes to instruction RAM.
// Latency: 4 write cycles per accepted word; in_ready is held low while those bytes drain.
module imem_loader #(
   parameter int          DEPTH = 128,
   parameter logic [31:0] BASE  = 32'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_word,
   input  logic        in_last,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [7:0]  mem_wd,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCEPT = 2'd1;
   localparam logic [1:0] WRITE  = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   // Highest byte address at which a whole word still fits.
   localparam logic [31:0] LAST_ADDR = 32'(DEPTH - 4);

   logic [1:0]  state;
   logic [31:0] addr;
   logic [1:0]  idx;
   logic [31:0] word;
   logic        last;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         addr  <= BASE;
         idx   <= 2'd0;
         word  <= 32'd0;
         last  <= 1'b0;
         err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  addr  <= BASE;
                  err   <= 1'b0;
                  state <= ACCEPT;
               end
            end
            ACCEPT: begin
               if (in_valid) begin
                  word <= in_word;
                  last <= in_last;
                  // A word that would run past the RAM is dropped and ends the session.
                  if (addr > LAST_ADDR) begin
                     err   <= 1'b1;
                     state <= DONE;
                  end else begin
                     idx   <= 2'd0;
                     state <= WRITE;
                  end
               end
            end
            WRITE: begin
               idx <= idx + 2'd1;
               if (idx == 2'd3) begin
                  addr  <= addr + 32'd4;
                  state <= last ? DONE : ACCEPT;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // All outputs decode from registered state, so an async reset clears them at once.
   always_comb begin
      in_ready = (state == ACCEPT);
      mem_we   = (state == WRITE);
      busy     = (state != IDLE);
      done     = (state == DONE);
      mem_addr = 32'd0;
      mem_wd   = 8'd0;
      if (state == WRITE) begin
         mem_addr = addr + {30'd0, idx};
         mem_wd   = word[{idx, 3'b000} +: 8];
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: driver queues expected byte writes, a negedge monitor checks them.
module tb_imem_loader;

   logic        clk;
   logic        reset;
   logic        start;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_word;
   logic        in_last;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [7:0]  mem_wd;
   logic        busy;
   logic        done;
   logic        err;

   imem_loader #(.DEPTH(128), .BASE(32'h0)) dut (
      .clk(clk), .reset(reset), .start(start),
      .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word), .in_last(in_last),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
      .busy(busy), .done(done), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int ncmp = 0;
   int nerr = 0;
   int cycle = 0;
   int acc_cycle = 0;
   int prev_acc = 0;

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  wd;
   } wr_t;

   wr_t expq[$];

   always @(posedge clk) cycle <= cycle + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every byte write must match the head of the expected queue.
   always @(negedge clk) begin
      wr_t e;
      if (!reset) begin
         if (mem_we) begin
            if (expq.size() == 0) begin
               chk("unexpected_write_addr", mem_addr, 32'hffff_ffff);
            end else begin
               e = expq.pop_front();
               chk("wr_addr", mem_addr, e.addr);
               chk("wr_data", {24'd0, mem_wd}, {24'd0, e.wd});
            end
         end else begin
            chk("idle_bus_zero", {mem_addr[23:0], mem_wd}, 32'd0);
         end
      end
   end

   task automatic push_word(input logic [31:0] a, input logic [31:0] w);
      for (int b = 0; b < 4; b++) begin
         wr_t e;
         e.addr = a + 32'(b);
         e.wd   = w[8*b +: 8];
         expq.push_back(e);
      end
   endtask

   // Called just after a negedge; returns at the negedge following the accept edge.
   task automatic send(input logic [31:0] w, input logic last);
      int n = 0;
      in_valid = 1'b1;
      while (!in_ready && n < 40) begin
         in_word = $urandom;
         in_last = 1'b0;
         @(negedge clk);
         n++;
      end
      chk("accept_timeout", {31'd0, in_ready}, 32'd1);
      in_word   = w;
      in_last   = last;
      prev_acc  = acc_cycle;
      acc_cycle = cycle;
      @(negedge clk);
      if (last) in_valid = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", {31'd0, busy}, 32'd1);
   endtask

   task automatic wait_done(input logic exp_err);
      int n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen", {31'd0, done}, 32'd1);
      chk("err_at_done", {31'd0, err}, {31'd0, exp_err});
      @(negedge clk);
      chk("done_one_cycle", {31'd0, done}, 32'd0);
      chk("idle_after_done", {30'd0, busy, in_ready}, 32'd0);
      chk("err_holds", {31'd0, err}, {31'd0, exp_err});
   endtask

   initial begin
      wr_t e;
      int n;
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_word = 32'd0; in_last = 1'b0;
      #1;
      chk("reset_outputs",
          {25'd0, in_ready, mem_we, busy, done, err, 2'd0} | mem_addr | {24'd0, mem_wd}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Single word
      do_start();
      push_word(32'd0, 32'h002307d3);
      send(32'h002307d3, 1'b1);
      wait_done(1'b0);

      // in_valid in IDLE is ignored
      in_valid = 1'b1;
      in_word  = 32'hdeadbeef;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("idle_in_ready", {31'd0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;

      // Back-to-back, 1 word per 5 cycles
      do_start();
      push_word(32'd0, 32'h01600113);
      push_word(32'd4, 32'h002081b3);
      push_word(32'd8, 32'h0021e233);
      send(32'h01600113, 1'b0);
      send(32'h002081b3, 1'b0);
      chk("b2b_interval_1", acc_cycle - prev_acc, 32'd5);
      send(32'h0021e233, 1'b1);
      chk("b2b_interval_2", acc_cycle - prev_acc, 32'd5);
      wait_done(1'b0);

      // start during WRITE is ignored
      do_start();
      push_word(32'd0, 32'h11223344);
      push_word(32'd4, 32'h55667788);
      send(32'h11223344, 1'b0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      send(32'h55667788, 1'b1);
      wait_done(1'b0);

      // Overflow: 33rd word dropped, err set
      do_start();
      for (int i = 0; i < 33; i++) begin
         logic [31:0] w;
         w = 32'ha0000000 + 32'(i) * 32'h00010203;
         if (i < 32) push_word(32'(4 * i), w);
         send(w, i == 32);
      end
      wait_done(1'b1);
      chk("overflow_all_written", expq.size(), 32'd0);

      // Restart clears err
      do_start();
      chk("err_cleared", {31'd0, err}, 32'd0);
      push_word(32'd0, 32'hcafef00d);
      send(32'hcafef00d, 1'b1);
      wait_done(1'b0);

      // Async reset during byte idx 2
      do_start();
      for (int b = 0; b < 3; b++) begin
         e.addr = 32'(b);
         e.wd   = 8'h10 + 8'(b);
         expq.push_back(e);
      end
      send(32'h13121110, 1'b0);
      n = 0;
      while (!(mem_we && mem_addr == 32'd2) && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("reached_byte2", mem_addr, 32'd2);
      #1 reset = 1'b1;
      in_valid = 1'b0;
      #1;
      chk("rst_async_drop", {29'd0, mem_we, busy, in_ready}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_reset_idle", {29'd0, mem_we, busy, in_ready}, 32'd0);
      end
      chk("queue_drained", expq.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
